wb_arbiter: RTL
===============

# wb_arbiter

Two-master, one-slave classic Wishbone arbiter that merges the core's instruction port and data port onto a single shared memory bus. It sits directly downstream of the core: the core's `instr_bus` and `data_bus` master ports connect to its two slave-side ports, and its master-side port drives the single memory/interconnect bus. The arbiter grants ownership per bus cycle (`cyc` framing) using round-robin priority. A bus watchdog converts a non-responding slave into a Wishbone error.

## Interface
Parameters:
- `XLEN`, 32: address/data width; `sel` is `XLEN/8` bits.
- `TIMEOUT`, 16: cycles a granted strobe may wait for `ack`/`err` before the watchdog fires; legal range 2..255.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `instr_bus` wishbone.SLAVE: from core fetch port. Uses `cyc`, `stb`, `we`, `adr[XLEN-1:0]`, `sel`, `dat_w`, `dat_r`, `ack`, `err`.
- `data_bus` wishbone.SLAVE: from core load/store port. Same signal set.
- `mem_bus` wishbone.MASTER: to shared memory/interconnect. Same signal set.

## Operation
- Grant state machine:
  - States: `IDLE`, `GNT_I`, `GNT_D`.
  - Register `last`: 0 = instruction, 1 = data.
- Transitions out of `IDLE`:
  - Only `data_bus.cyc` is high: go to `GNT_D`.
  - Only `instr_bus.cyc` is high: go to `GNT_I`.
  - Both are high: grant the master not equal to `last`.
- `GNT_x` holds while master x keeps `cyc` high, including across multiple strobes. Master x dropping `cyc` returns the arbiter to `IDLE` on the next edge, and `last` is set to x.
- No back-to-back regrant without passing through `IDLE`. This bounds the worst-case wait for either master to one bus cycle plus 2 clocks.
- Forwarding:
  - In `GNT_x`, `mem_bus` `cyc`, `stb`, `we`, `adr`, `sel` and `dat_w` are combinational copies of master x.
  - Master x receives `mem_bus` `dat_r`, `ack` and `err`.
  - The non-granted master sees `ack=0`, `err=0` and `dat_r=0`.
  - In `IDLE`, all `mem_bus` outputs are 0.
- Watchdog:
  - An 8-bit counter `wd` clears whenever `mem_bus.stb` is low or `ack`/`err` is high. Otherwise it increments each cycle while `mem_bus.stb` is high.
  - When `wd == TIMEOUT-1` and no `ack`/`err`, the arbiter:
    - asserts `err` to the granted master for exactly that one cycle;
    - forces `mem_bus.cyc`/`stb` low for that cycle and the next;
    - returns to `IDLE` on the following edge.
  - A late slave `ack` after a timeout is ignored and not forwarded.
- A master dropping `stb` mid-cycle while keeping `cyc` is legal. The grant is held and the watchdog clears.

## Timing
- Reset values:
  - state = `IDLE`, `last` = 0, `wd` = 0.
  - All `mem_bus` outputs are 0.
  - All `ack`/`err`/`dat_r` to both masters are 0.
- Reset mid-transfer aborts immediately: outputs are 0 the cycle after the reset edge, and any in-flight `ack` is dropped.
- Arbitration latency:
  - A master requesting in `IDLE` at cycle N is granted at edge N+1.
  - `mem_bus.cyc/stb` are visible in cycle N+1.
- Data path latency is zero cycles after grant. `ack` from the slave in cycle M reaches the master in cycle M.
- Release:
  - `cyc` low in cycle K gives `IDLE` in K+1.
  - The other pending master is granted at K+2.
- Both masters requesting in the same `IDLE` cycle is resolved purely by `last`. The first tie after reset goes to data.
- Watchdog: with no response, `err` is asserted in the `TIMEOUT`-th cycle of `stb` high (cycle S+TIMEOUT-1 for `stb` rising in S).

## Test plan
- Single fetch: `instr_bus.cyc/stb` with `adr=0x100` at cycle 0; slave acks in cycle 2 with `dat_r=0x00000013` -> `mem_bus.adr=0x100` from cycle 1; `instr_bus.ack=1` and `dat_r=0x13` in cycle 2; `data_bus.ack=0` throughout.
- Simultaneous requests after reset -> data granted at cycle 1. Instruction is granted 2 cycles after data drops `cyc`. A second simultaneous tie then goes to instruction.
- Store while fetch is in progress (`we=1`, `sel=4'b0011`, `dat_w=0xDEADBEEF`) -> store is not forwarded until fetch `cyc` falls. The store then appears on `mem_bus` with its `we`, `sel` and `dat_w` intact.
- Multi-strobe locked cycle: data holds `cyc` across 3 acked strobes while instruction requests -> no regrant until `cyc` falls.
- Watchdog with `TIMEOUT=16` and a silent slave -> `data_bus.err=1` for one cycle, 16 cycles after `stb` rose. `mem_bus.cyc` is 0 the next 2 cycles. A subsequent late `ack` is not forwarded.
- `rst_n` low during a granted cycle -> all outputs 0 next cycle. After release, the first tie is granted to data.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Classic Wishbone signal bundle shared by the arbiter's slave-side and master-side ports.
interface wishbone #(
  parameter int XLEN = 32
) ();
  logic              cyc;
  logic              stb;
  logic              we;
  logic [XLEN-1:0]   adr;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic              ack;
  logic              err;

  modport MASTER (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
  modport SLAVE  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone arbiter (instruction/data onto one memory bus)
// with a strobe watchdog that turns a silent slave into a bus error.
module wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic     clk,
  input logic     rst_n,
  wishbone.SLAVE  instr_bus,
  wishbone.SLAVE  data_bus,
  wishbone.MASTER mem_bus
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] wd_q, wd_d;

  logic              own_i, own_d, granted;
  logic              m_cyc, m_stb, m_we;
  logic [XLEN-1:0]   m_adr, m_dat_w;
  logic [XLEN/8-1:0] m_sel;
  logic              slv_resp, timeout;

  always_comb begin
    own_i    = (state_q == GNT_I);
    own_d    = (state_q == GNT_D);
    granted  = own_i | own_d;
    m_cyc    = own_d ? data_bus.cyc   : instr_bus.cyc;
    m_stb    = own_d ? data_bus.stb   : instr_bus.stb;
    m_we     = own_d ? data_bus.we    : instr_bus.we;
    m_adr    = own_d ? data_bus.adr   : instr_bus.adr;
    m_sel    = own_d ? data_bus.sel   : instr_bus.sel;
    m_dat_w  = own_d ? data_bus.dat_w : instr_bus.dat_w;
    slv_resp = mem_bus.ack | mem_bus.err;
    timeout  = granted & m_stb & ~slv_resp & (wd_q == WD_LAST);
  end

  // The watchdog cycle itself withdraws cyc/stb; the following IDLE cycle keeps them low.
  assign mem_bus.cyc   = granted & m_cyc & ~timeout;
  assign mem_bus.stb   = granted & m_stb & ~timeout;
  assign mem_bus.we    = granted & m_we;
  assign mem_bus.adr   = granted ? m_adr   : '0;
  assign mem_bus.sel   = granted ? m_sel   : '0;
  assign mem_bus.dat_w = granted ? m_dat_w : '0;

  assign instr_bus.ack   = own_i & mem_bus.ack & ~timeout;
  assign instr_bus.err   = own_i & (mem_bus.err | timeout);
  assign instr_bus.dat_r = own_i ? mem_bus.dat_r : '0;
  assign data_bus.ack    = own_d & mem_bus.ack & ~timeout;
  assign data_bus.err    = own_d & (mem_bus.err | timeout);
  assign data_bus.dat_r  = own_d ? mem_bus.dat_r : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (instr_bus.cyc && data_bus.cyc) state_d = last_q ? GNT_I : GNT_D;
        else if (data_bus.cyc)             state_d = GNT_D;
        else if (instr_bus.cyc)            state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (timeout || !m_cyc) begin
          // Ownership ends: remember who held the bus so a tie favours the other master.
          state_d = IDLE;
          last_d  = own_d;
          wd_d    = '0;
        end else if (!m_stb || slv_resp) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end
endmodule
